multi_degree_offset_prefetcher: RTL
===================================

// Module: multi_degree_offset_prefetcher
// PURPOSE
//  Parametrised best-offset (BO) prefetcher between an upper cache and the next level. Learns one
//  line offset per learning phase by scoring candidate offsets against a recent-requests (RR)
//  table. Issues DEGREE prefetches per trigger (B+D, B+2D, ...) through a valid/ready request
//  FIFO, and drops any candidate that crosses a page boundary.
// PARAMETERS
//  LINE_W      32   line-address width in bits (byte address >> log2(line size))
//  NOFFSETS    46   number of candidates used, 1..46, taken in order from the fixed table
//                   +1,-1,+2,-2,...,+16,-16,+18,-18,+20,-20,+24,-24,+30,-30,+32,-32,+36,-36,+40,-40
//  SCORE_MAX   31   score saturation value; reaching it ends the phase early
//  ROUND_MAX   100  rounds per learning phase (1 round = NOFFSETS tests)
//  BAD_SCORE   1    phase best score <= BAD_SCORE switches prefetching off
//  RR_IDX_W    6    RR table index bits (2**RR_IDX_W direct-mapped entries)
//  RR_TAG_W    12   RR partial-tag bits
//  DEGREE      2    prefetches per trigger, 1..4
//  QDEPTH      8    request FIFO entries (power of 2)
//  PAGE_LINES  64   lines per page (power of 2); candidates stay within the trigger's page
// PORTS
//  clk               in   1       clock
//  rst               in   1       synchronous active-high reset
//  acc_valid_i       in   1       upper-cache access this cycle
//  acc_line_i        in   LINE_W  access line address
//  acc_miss_i        in   1       access missed
//  acc_prefetched_i  in   1       access hit a line whose prefetched bit is set (first use)
//  fill_valid_i      in   1       fill into upper cache completed
//  fill_line_i       in   LINE_W  filled line address
//  fill_prefetched_i in   1       fill was a prefetch
//  pf_valid_o        out  1       prefetch request valid (FIFO head)
//  pf_line_o         out  LINE_W  prefetch line address
//  pf_ready_i        in   1       lower level accepts the request
//  best_offset_o     out  7       signed current prefetch offset (0 = off)
//  best_score_o      out  5       score that selected best_offset_o
// BEHAVIOUR
//  Reset: single clock clk; synchronous active-high rst. All scores, round/index counters and RR
//    valid bits cleared; FIFO emptied; pf_valid_o=0, pf_line_o=0; best_offset_o=+1,
//    best_score_o=0. Reset mid-burst discards queued and pending requests.
//  Trigger: acc_valid_i & (acc_miss_i | acc_prefetched_i). Non-trigger accesses have no effect.
//  Learning (per trigger, registered at the clock edge): test offset O=OFFSET[p], where p is the
//    candidate index. Look up RR with acc_line_i - O (combinational read).
//    - Hit: score[p] is saturating-incremented. The phase best is updated when the new score is
//      >= the current best, so ties go to the later index.
//    - p wraps NOFFSETS-1 -> 0 and increments the round counter.
//    - Phase ends when a new score == SCORE_MAX, or at wrap with round+1 == ROUND_MAX.
//      Next cycle: best_offset_o = best offset (0 if best score <= BAD_SCORE) and
//      best_score_o = best score. Then scores, best, p and round all clear.
//  RR insert, one per cycle, direct-mapped, overwrite:
//    - fill_valid_i & fill_prefetched_i: insert fill_line_i - best_offset_o.
//    - Prefetching off (best_offset_o == 0): each trigger inserts acc_line_i.
//    - Both in one cycle: the fill insert wins. Index = low RR_IDX_W bits; tag = next RR_TAG_W bits.
//  Issue FSM, states IDLE and BURST:
//    - IDLE -> BURST on a trigger with best_offset_o != 0; latch base B and D = best_offset_o, k = 1.
//    - BURST: each cycle, compute cand = B + k*D (mod 2**LINE_W).
//      - Drop cand if cand/PAGE_LINES != B/PAGE_LINES; a dropped cand also ends the burst.
//      - Otherwise push cand; if the FIFO is full, drop it and continue.
//      - k == DEGREE or a page drop -> IDLE.
//    - A trigger arriving in BURST still learns but starts no burst (no queueing of triggers).
//  FIFO: pf_valid_o = !empty; pop when pf_valid_o & pf_ready_i. Push and pop in the same cycle
//    are legal when full. pf_line_o holds stable while valid and not ready. The first request
//    appears 2 cycles after the trigger edge.
// CONFIGURATION
//  ADAPTIVE_DEGREE_EN defined: the burst length is DEGREE when best_score_o >= SCORE_MAX/2
//    (integer division), otherwise 1.
//  ADAPTIVE_DEGREE_EN undefined: the burst length is always DEGREE.
// TESTING
//  1 Reset then a miss at line 0x100 (offset +1): FIFO gets 0x101, 0x102; pf_valid_o rises at
//    edge 2.
//  2 Stream of misses at 0x1000+3n with fills marked prefetched: within 1 phase best_offset_o=+3,
//    best_score_o=31.
//  3 Random non-repeating misses for 100 rounds: best_score_o<=1, best_offset_o=0, no further
//    pf_valid_o.
//  4 PAGE_LINES=64, offset +1, miss at 0x13F: no request (0x140 crosses page); miss at 0x13E:
//    only 0x13F issued.
//  5 pf_ready_i=0 with 10 triggers, DEGREE=2, QDEPTH=8: 8 entries held in order; pf_line_o stable;
//    rest dropped.
//  6 rst asserted during BURST with 3 queued: next cycle pf_valid_o=0, best_offset_o=+1, scores
//    zero.

Source files
------------

// File: rtl/multi_degree_offset_prefetcher.sv
// Best-offset prefetcher: learns one line offset per phase from an RR table and issues
// DEGREE page-bounded prefetches per trigger. Optional macro: ADAPTIVE_DEGREE_EN.
module multi_degree_offset_prefetcher #(
    parameter int LINE_W     = 32,
    parameter int NOFFSETS   = 46,
    parameter int SCORE_MAX  = 31,
    parameter int ROUND_MAX  = 100,
    parameter int BAD_SCORE  = 1,
    parameter int RR_IDX_W   = 6,
    parameter int RR_TAG_W   = 12,
    parameter int DEGREE     = 2,
    parameter int QDEPTH     = 8,
    parameter int PAGE_LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_valid_i,
    input  logic [LINE_W-1:0] acc_line_i,
    input  logic              acc_miss_i,
    input  logic              acc_prefetched_i,
    input  logic              fill_valid_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic              fill_prefetched_i,
    output logic              pf_valid_o,
    output logic [LINE_W-1:0] pf_line_o,
    input  logic              pf_ready_i,
    output logic [6:0]        best_offset_o,
    output logic [4:0]        best_score_o
);
    localparam int SC_W   = 5;
    localparam int P_W    = (NOFFSETS > 1) ? $clog2(NOFFSETS) : 1;
    localparam int R_W    = (ROUND_MAX > 1) ? $clog2(ROUND_MAX) : 1;
    localparam int RR_N   = 1 << RR_IDX_W;
    localparam int RR_LOW = RR_IDX_W + RR_TAG_W;
    localparam int PG_W   = $clog2(PAGE_LINES);
    localparam int QA_W   = $clog2(QDEPTH);
    localparam int K_W    = 3;

    localparam logic [SC_W-1:0] SC_MAX_V = SC_W'(SCORE_MAX);
    localparam logic [SC_W-1:0] BAD_V    = SC_W'(BAD_SCORE);
    localparam logic [P_W-1:0]  P_LAST   = P_W'(NOFFSETS - 1);
    localparam logic [R_W-1:0]  R_LAST   = R_W'(ROUND_MAX - 1);

    // Candidate table: pairs +m,-m over magnitudes 1..16,18,20,24,30,32,36,40.
    function automatic logic [6:0] offset_at(input int p);
        int mag;
        int i;
        i = p >> 1;
        if (i < 16) begin
            mag = i + 1;
        end else begin
            case (i)
                16: mag = 18;
                17: mag = 20;
                18: mag = 24;
                19: mag = 30;
                20: mag = 32;
                21: mag = 36;
                default: mag = 40;
            endcase
        end
        return p[0] ? 7'(-mag) : 7'(mag);
    endfunction

    logic trig;
    assign trig = acc_valid_i & (acc_miss_i | acc_prefetched_i);

    // ---------------- learning state ----------------
    logic [SC_W-1:0] score_q [NOFFSETS];
    logic [P_W-1:0]  p_q;
    logic [R_W-1:0]  round_q;
    logic [P_W-1:0]  best_idx_q, best_idx_n;
    logic [SC_W-1:0] best_sc_q, best_sc_n;
    logic [6:0]      best_off_q;
    logic [SC_W-1:0] best_score_q;

    logic [RR_N-1:0]     rr_v_q;
    logic [RR_TAG_W-1:0] rr_tag_q [RR_N];

    logic [6:0]        cur_off;
    logic [RR_LOW-1:0] look;
    logic              rr_hit;
    logic [SC_W-1:0]   score_inc;
    logic              phase_end;
    logic              wrap;

    assign cur_off   = offset_at(int'(p_q));
    assign look      = acc_line_i[RR_LOW-1:0] - {{(RR_LOW-7){cur_off[6]}}, cur_off};
    assign rr_hit    = rr_v_q[look[RR_IDX_W-1:0]] &&
                       (rr_tag_q[look[RR_IDX_W-1:0]] == look[RR_LOW-1:RR_IDX_W]);
    assign score_inc = (score_q[p_q] == SC_MAX_V) ? score_q[p_q] : score_q[p_q] + SC_W'(1);
    assign wrap      = (p_q == P_LAST);

    always_comb begin
        best_idx_n = best_idx_q;
        best_sc_n  = best_sc_q;
        phase_end  = 1'b0;
        if (rr_hit) begin
            // >= lets the later candidate win a tie
            if (score_inc >= best_sc_q) begin
                best_idx_n = p_q;
                best_sc_n  = score_inc;
            end
            if (score_inc == SC_MAX_V) phase_end = 1'b1;
        end
        if (wrap && (round_q == R_LAST)) phase_end = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NOFFSETS; i++) score_q[i] <= '0;
            p_q          <= '0;
            round_q      <= '0;
            best_idx_q   <= '0;
            best_sc_q    <= '0;
            best_off_q   <= 7'd1;
            best_score_q <= '0;
        end else if (trig) begin
            if (phase_end) begin
                for (int i = 0; i < NOFFSETS; i++) score_q[i] <= '0;
                p_q          <= '0;
                round_q      <= '0;
                best_idx_q   <= '0;
                best_sc_q    <= '0;
                best_off_q   <= (best_sc_n <= BAD_V) ? 7'd0 : offset_at(int'(best_idx_n));
                best_score_q <= best_sc_n;
            end else begin
                if (rr_hit) score_q[p_q] <= score_inc;
                best_idx_q <= best_idx_n;
                best_sc_q  <= best_sc_n;
                if (wrap) begin
                    p_q     <= '0;
                    round_q <= round_q + R_W'(1);
                end else begin
                    p_q <= p_q + P_W'(1);
                end
            end
        end
    end

    // ---------------- RR table insert ----------------
    logic              ins_en;
    logic [RR_LOW-1:0] ins_line;
    logic              unused_line_hi;

    assign unused_line_hi = ^fill_line_i[LINE_W-1:RR_LOW];

    always_comb begin
        ins_en   = 1'b0;
        ins_line = '0;
        // prefetched fills record the trigger that would have produced them
        if (fill_valid_i && fill_prefetched_i) begin
            ins_en   = 1'b1;
            ins_line = fill_line_i[RR_LOW-1:0] - {{(RR_LOW-7){best_off_q[6]}}, best_off_q};
        end else if (trig && (best_off_q == 7'd0)) begin
            ins_en   = 1'b1;
            ins_line = acc_line_i[RR_LOW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_v_q <= '0;
        end else if (ins_en) begin
            rr_v_q[ins_line[RR_IDX_W-1:0]]   <= 1'b1;
            rr_tag_q[ins_line[RR_IDX_W-1:0]] <= ins_line[RR_LOW-1:RR_IDX_W];
        end
    end

    // ---------------- issue FSM ----------------
    typedef enum logic {S_IDLE, S_BURST} state_t;
    state_t state_q, state_d;

    logic [LINE_W-1:0] base_q, base_d;
    logic [6:0]        dist_q, dist_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [K_W-1:0]    len_q, len_d;
    logic [K_W-1:0]    burst_len;
    logic              stage_v_q, stage_v_d;
    logic [LINE_W-1:0] stage_line_q, stage_line_d;
    logic [LINE_W-1:0] cand;

`ifdef ADAPTIVE_DEGREE_EN
    assign burst_len = (best_score_q >= SC_W'(SCORE_MAX / 2)) ? K_W'(DEGREE) : K_W'(1);
`else
    assign burst_len = K_W'(DEGREE);
`endif

    assign cand = base_q + {{(LINE_W-7){dist_q[6]}}, dist_q} * LINE_W'(k_q);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        dist_d       = dist_q;
        k_d          = k_q;
        len_d        = len_q;
        stage_v_d    = 1'b0;
        stage_line_d = stage_line_q;
        case (state_q)
            S_IDLE: begin
                if (trig && (best_off_q != 7'd0)) begin
                    state_d = S_BURST;
                    base_d  = acc_line_i;
                    dist_d  = best_off_q;
                    k_d     = K_W'(1);
                    len_d   = burst_len;
                end
            end
            S_BURST: begin
                if (cand[LINE_W-1:PG_W] != base_q[LINE_W-1:PG_W]) begin
                    state_d = S_IDLE;
                end else begin
                    stage_v_d    = 1'b1;
                    stage_line_d = cand;
                    if (k_q == len_q) state_d = S_IDLE;
                    else              k_d     = k_q + K_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            dist_q       <= '0;
            k_q          <= '0;
            len_q        <= '0;
            stage_v_q    <= 1'b0;
            stage_line_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            dist_q       <= dist_d;
            k_q          <= k_d;
            len_q        <= len_d;
            stage_v_q    <= stage_v_d;
            stage_line_q <= stage_line_d;
        end
    end

    // ---------------- request FIFO ----------------
    // valid/ready: a request transfers on a cycle where pf_valid_o and pf_ready_i are both high;
    // while valid and not ready the head and pf_line_o hold.
    logic [LINE_W-1:0] mem_q [QDEPTH];
    logic [QA_W:0]     wr_q, rd_q;
    logic              empty, full, push, pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[QA_W] != rd_q[QA_W]) && (wr_q[QA_W-1:0] == rd_q[QA_W-1:0]);
    assign pop   = pf_valid_o & pf_ready_i;
    assign push  = stage_v_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q[QA_W-1:0]] <= stage_line_q;
                wr_q <= wr_q + (QA_W+1)'(1);
            end
            if (pop) rd_q <= rd_q + (QA_W+1)'(1);
        end
    end

    assign pf_valid_o    = ~empty;
    assign pf_line_o     = empty ? '0 : mem_q[rd_q[QA_W-1:0]];
    assign best_offset_o = best_off_q;
    assign best_score_o  = best_score_q;
endmodule
